exc_ctrl: RTL and testbench

- Exception/interrupt arbiter sitting directly upstream of the CP0 register file.
- Samples the exception flags carried by the instruction in the MEM stage and synchronises the external interrupt lines.
- Picks one event by fixed priority and drives the CP0 exception/ERET inputs.
- Flushes the pipeline for a fixed number of cycles and issues a single PC redirect, either to the exception entry or to EPC.

---
 rtl/exc_ctrl.sv | 149 ++++++++++++++
 tb/tb_exc_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Exception/interrupt arbiter ahead of CP0: picks one event per MEM instruction,
// drives the CP0 exception/ERET inputs, flushes the pipeline and redirects the PC.
module exc_ctrl #(
  parameter logic [31:0] EXC_ENTRY    = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hw_int_raw_i,
  output logic [5:0]  hw_int_o,
  input  logic        m_valid_i,
  input  logic [31:0] m_pc_i,
  input  logic        m_in_ds_i,
  input  logic        m_exc_if_adel_i,
  input  logic        m_exc_ri_i,
  input  logic        m_exc_sys_i,
  input  logic        m_exc_bp_i,
  input  logic        m_exc_ov_i,
  input  logic        m_exc_adel_i,
  input  logic        m_exc_ades_i,
  input  logic [31:0] m_data_addr_i,
  input  logic        m_eret_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic        exc_valid_o,
  output logic [4:0]  exc_code_o,
  output logic [31:0] exc_pc_o,
  output logic        exc_in_ds_o,
  output logic [31:0] exc_badvaddr_o,
  output logic        eret_o,
  output logic        mem_kill_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  logic [5:0]         sync_q [SYNC_STAGES];

  logic               int_pend;
  logic               act;
  logic               exc_any;
  logic [4:0]         code;
  logic [31:0]        badvaddr;
  logic               cp0_unused;

  assign cp0_unused = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= hw_int_raw_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign hw_int_o = sync_q[SYNC_STAGES-1];

  assign int_pend = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
  assign act      = (state_q == IDLE) & m_valid_i;

  // Fixed priority: interrupt first, then the oldest pipeline stage's fault.
  always_comb begin
    exc_any  = 1'b1;
    code     = 5'h00;
    badvaddr = 32'h0;
    if (int_pend) begin
      code = 5'h00;
    end else if (m_exc_if_adel_i) begin
      code     = 5'h04;
      badvaddr = m_pc_i;
    end else if (m_exc_ri_i) begin
      code = 5'h0a;
    end else if (m_exc_sys_i) begin
      code = 5'h08;
    end else if (m_exc_bp_i) begin
      code = 5'h09;
    end else if (m_exc_ov_i) begin
      code = 5'h0c;
    end else if (m_exc_adel_i) begin
      code     = 5'h04;
      badvaddr = m_data_addr_i;
    end else if (m_exc_ades_i) begin
      code     = 5'h05;
      badvaddr = m_data_addr_i;
    end else begin
      exc_any = 1'b0;
    end
  end

  assign exc_valid_o    = act & exc_any;
  assign mem_kill_o     = act & exc_any;
  assign exc_code_o     = exc_valid_o ? code : 5'h00;
  assign exc_badvaddr_o = exc_valid_o ? badvaddr : 32'h0;
  assign exc_pc_o       = exc_valid_o ? m_pc_i : 32'h0;
  assign exc_in_ds_o    = exc_valid_o & m_in_ds_i;
  assign eret_o         = act & m_eret_i & ~exc_any;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (exc_valid_o || eret_o) begin
          state_d          = FLUSH;
          cnt_d            = CNT_W'(FLUSH_CYCLES - 1);
          redirect_valid_d = 1'b1;
          redirect_pc_d    = exc_valid_o ? EXC_ENTRY : epc_i;
        end
      end
      FLUSH: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign flush_o          = (state_q == FLUSH);
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: priority, CP0 handoff, flush/redirect timing and reset.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  hw_int_raw_i, hw_int_o;
  logic        m_valid_i, m_in_ds_i, m_eret_i;
  logic        m_exc_if_adel_i, m_exc_ri_i, m_exc_sys_i, m_exc_bp_i;
  logic        m_exc_ov_i, m_exc_adel_i, m_exc_ades_i;
  logic [31:0] m_pc_i, m_data_addr_i, status_i, cause_i, epc_i;
  logic        exc_valid_o, exc_in_ds_o, eret_o, mem_kill_o, flush_o, redirect_valid_o;
  logic [4:0]  exc_code_o;
  logic [31:0] exc_pc_o, exc_badvaddr_o, redirect_pc_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .hw_int_raw_i(hw_int_raw_i), .hw_int_o(hw_int_o),
    .m_valid_i(m_valid_i), .m_pc_i(m_pc_i), .m_in_ds_i(m_in_ds_i),
    .m_exc_if_adel_i(m_exc_if_adel_i), .m_exc_ri_i(m_exc_ri_i), .m_exc_sys_i(m_exc_sys_i),
    .m_exc_bp_i(m_exc_bp_i), .m_exc_ov_i(m_exc_ov_i), .m_exc_adel_i(m_exc_adel_i),
    .m_exc_ades_i(m_exc_ades_i), .m_data_addr_i(m_data_addr_i), .m_eret_i(m_eret_i),
    .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
    .exc_valid_o(exc_valid_o), .exc_code_o(exc_code_o), .exc_pc_o(exc_pc_o),
    .exc_in_ds_o(exc_in_ds_o), .exc_badvaddr_o(exc_badvaddr_o), .eret_o(eret_o),
    .mem_kill_o(mem_kill_o), .flush_o(flush_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o)
  );

  task automatic clear_inputs();
    m_valid_i = 0; m_in_ds_i = 0; m_eret_i = 0; m_exc_if_adel_i = 0; m_exc_ri_i = 0;
    m_exc_sys_i = 0; m_exc_bp_i = 0; m_exc_ov_i = 0; m_exc_adel_i = 0; m_exc_ades_i = 0;
    m_pc_i = 0; m_data_addr_i = 0; status_i = 0; cause_i = 0; epc_i = 0;
  endtask

  // Accept the pending event on the next edge, then let the 2-cycle flush expire.
  task automatic drain();
    @(posedge clk); #1 clear_inputs();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; hw_int_raw_i = 0; clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({exc_valid_o, eret_o, mem_kill_o, flush_o, redirect_valid_o} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {exc_valid_o, eret_o, mem_kill_o, flush_o, redirect_valid_o}); end
    checks++; if (redirect_pc_o !== 32'h0 || hw_int_o !== 6'h0) begin
      failures++; $display("FAIL reset_data redirect_pc=%h hw_int=%b exp=0", redirect_pc_o, hw_int_o); end
    @(negedge clk) rst = 0;
    repeat (2) @(negedge clk);
    hw_int_raw_i = 6'b000001;
    @(posedge clk); #1;
    checks++; if (hw_int_o !== 6'b000000) begin
      failures++; $display("FAIL sync_edge1 got=%b exp=000000", hw_int_o); end
    @(posedge clk); #1;
    checks++; if (hw_int_o !== 6'b000001) begin
      failures++; $display("FAIL sync_edge2 got=%b exp=000001", hw_int_o); end
    hw_int_raw_i = 6'b100000;
  endtask

  task automatic test_ov();
    @(negedge clk);
    m_valid_i = 1; m_pc_i = 32'h80001004; m_in_ds_i = 1; m_exc_ov_i = 1;
    #1;
    checks++; if ({exc_valid_o, mem_kill_o, exc_in_ds_o, eret_o} !== 4'b1110 || exc_code_o !== 5'h0c) begin
      failures++; $display("FAIL ov_flags got=%b code=%h exp=1110 code=0c", {exc_valid_o, mem_kill_o, exc_in_ds_o, eret_o}, exc_code_o); end
    checks++; if (exc_pc_o !== 32'h80001004 || exc_badvaddr_o !== 32'h0) begin
      failures++; $display("FAIL ov_pc got=%h bad=%h exp=80001004 bad=0", exc_pc_o, exc_badvaddr_o); end
    @(posedge clk); #1;
    checks++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'hBFC00380 || flush_o !== 1'b1) begin
      failures++; $display("FAIL ov_redirect rv=%b pc=%h fl=%b exp=1 bfc00380 1", redirect_valid_o, redirect_pc_o, flush_o); end
    checks++; if (exc_valid_o !== 1'b0 || mem_kill_o !== 1'b0) begin
      failures++; $display("FAIL ov_flush_ignore exc=%b kill=%b exp=0 0", exc_valid_o, mem_kill_o); end
    clear_inputs();
    @(posedge clk); #1;
    checks++; if (flush_o !== 1'b1 || redirect_valid_o !== 1'b0 || redirect_pc_o !== 32'hBFC00380) begin
      failures++; $display("FAIL ov_flush2 fl=%b rv=%b pc=%h exp=1 0 bfc00380", flush_o, redirect_valid_o, redirect_pc_o); end
    @(posedge clk); #1;
    checks++; if (flush_o !== 1'b0) begin
      failures++; $display("FAIL ov_flush_end got=%b exp=0", flush_o); end
  endtask

  task automatic test_interrupt();
    @(negedge clk);
    m_valid_i = 1; m_exc_sys_i = 1; status_i = 32'h0000FF01; cause_i = 32'h00000400;
    #1;
    checks++; if (exc_valid_o !== 1'b1 || exc_code_o !== 5'h00) begin
      failures++; $display("FAIL int_wins exc=%b code=%h exp=1 00", exc_valid_o, exc_code_o); end
    drain();
    @(negedge clk);
    m_valid_i = 1; m_exc_sys_i = 1; status_i = 32'h0000FF03; cause_i = 32'h00000400;
    #1;
    checks++; if (exc_valid_o !== 1'b1 || exc_code_o !== 5'h08) begin
      failures++; $display("FAIL int_exl_sys exc=%b code=%h exp=1 08", exc_valid_o, exc_code_o); end
    m_valid_i = 0;
    #1;
    checks++; if (exc_valid_o !== 1'b0 || mem_kill_o !== 1'b0 || exc_code_o !== 5'h00) begin
      failures++; $display("FAIL novalid exc=%b kill=%b code=%h exp=0 0 00", exc_valid_o, mem_kill_o, exc_code_o); end
    m_valid_i = 1;
    drain();
  endtask

  task automatic test_addr();
    @(negedge clk);
    m_valid_i = 1; m_exc_ades_i = 1; m_data_addr_i = 32'h80000003; m_pc_i = 32'h80000101;
    #1;
    checks++; if (exc_code_o !== 5'h05 || exc_badvaddr_o !== 32'h80000003) begin
      failures++; $display("FAIL ades code=%h bad=%h exp=05 80000003", exc_code_o, exc_badvaddr_o); end
    m_exc_if_adel_i = 1;
    #1;
    checks++; if (exc_code_o !== 5'h04 || exc_badvaddr_o !== 32'h80000101) begin
      failures++; $display("FAIL if_adel code=%h bad=%h exp=04 80000101", exc_code_o, exc_badvaddr_o); end
    m_exc_if_adel_i = 0; m_exc_ades_i = 0; m_exc_adel_i = 1; m_exc_bp_i = 1;
    #1;
    checks++; if (exc_code_o !== 5'h09 || exc_badvaddr_o !== 32'h0) begin
      failures++; $display("FAIL bp_over_adel code=%h bad=%h exp=09 0", exc_code_o, exc_badvaddr_o); end
    m_exc_bp_i = 0;
    #1;
    checks++; if (exc_code_o !== 5'h04 || exc_badvaddr_o !== 32'h80000003) begin
      failures++; $display("FAIL adel code=%h bad=%h exp=04 80000003", exc_code_o, exc_badvaddr_o); end
    drain();
  endtask

  task automatic test_eret();
    @(negedge clk);
    m_valid_i = 1; m_eret_i = 1; epc_i = 32'h80002000;
    #1;
    checks++; if ({eret_o, mem_kill_o, exc_valid_o} !== 3'b100) begin
      failures++; $display("FAIL eret_flags got=%b exp=100", {eret_o, mem_kill_o, exc_valid_o}); end
    @(posedge clk); #1;
    checks++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h80002000) begin
      failures++; $display("FAIL eret_redirect rv=%b pc=%h exp=1 80002000", redirect_valid_o, redirect_pc_o); end
    m_exc_ri_i = 1;
    #1;
    checks++; if ({exc_valid_o, mem_kill_o, eret_o} !== 3'b000) begin
      failures++; $display("FAIL eret_flush_ri got=%b exp=000", {exc_valid_o, mem_kill_o, eret_o}); end
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_valid_i = 1; m_eret_i = 1; m_exc_ov_i = 1; epc_i = 32'h80003000;
    #1;
    checks++; if ({eret_o, exc_valid_o, mem_kill_o} !== 3'b011 || exc_code_o !== 5'h0c) begin
      failures++; $display("FAIL eret_vs_ov got=%b code=%h exp=011 0c", {eret_o, exc_valid_o, mem_kill_o}, exc_code_o); end
    @(posedge clk); #1;
    checks++; if (redirect_pc_o !== 32'hBFC00380) begin
      failures++; $display("FAIL eret_vs_ov_pc got=%h exp=bfc00380", redirect_pc_o); end
    clear_inputs();
    repeat (2) @(posedge clk);
  endtask

  task automatic test_rst_mid_flush();
    @(negedge clk);
    m_valid_i = 1; m_exc_bp_i = 1;
    @(posedge clk); #1;
    clear_inputs();
    checks++; if (flush_o !== 1'b1 || redirect_valid_o !== 1'b1) begin
      failures++; $display("FAIL rst_pre fl=%b rv=%b exp=1 1", flush_o, redirect_valid_o); end
    rst = 1;
    #1;
    checks++; if (flush_o !== 1'b0 || redirect_valid_o !== 1'b0 || redirect_pc_o !== 32'h0) begin
      failures++; $display("FAIL rst_mid fl=%b rv=%b pc=%h exp=0 0 0", flush_o, redirect_valid_o, redirect_pc_o); end
    @(negedge clk) rst = 0;
    m_valid_i = 1; m_exc_ri_i = 1; m_pc_i = 32'h80004000;
    #1;
    checks++; if (exc_valid_o !== 1'b1 || exc_code_o !== 5'h0a || exc_pc_o !== 32'h80004000) begin
      failures++; $display("FAIL rst_after exc=%b code=%h pc=%h exp=1 0a 80004000", exc_valid_o, exc_code_o, exc_pc_o); end
    @(posedge clk); #1;
    checks++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'hBFC00380) begin
      failures++; $display("FAIL rst_after_redirect rv=%b pc=%h exp=1 bfc00380", redirect_valid_o, redirect_pc_o); end
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    m_valid_i = 1; m_eret_i = 1; epc_i = 32'h80005000;
    drain();
    checks++; if (flush_o !== 1'b0 || redirect_pc_o !== 32'h80005000) begin
      failures++; $display("FAIL b2b_idle fl=%b pc=%h exp=0 80005000", flush_o, redirect_pc_o); end
    m_valid_i = 1; m_exc_sys_i = 1; m_pc_i = 32'h80006000;
    #1;
    checks++; if (exc_valid_o !== 1'b1 || exc_code_o !== 5'h08) begin
      failures++; $display("FAIL b2b_accept exc=%b code=%h exp=1 08", exc_valid_o, exc_code_o); end
    @(posedge clk); #1;
    checks++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'hBFC00380) begin
      failures++; $display("FAIL b2b_redirect rv=%b pc=%h exp=1 bfc00380", redirect_valid_o, redirect_pc_o); end
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (hw_int_o !== 6'b100000) begin
      failures++; $display("FAIL sync_hold got=%b exp=100000", hw_int_o); end
  endtask

  initial begin
    test_reset();
    test_ov();
    test_interrupt();
    test_addr();
    test_eret();
    test_rst_mid_flush();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
